// File: rtl/serial4_tx.sv
// serial4_tx: framed parallel-to-serial transmitter (start, data LSB first, stop).
// Ports: clk, reset (sync, active-high), data/load in, ready/sout/busy/done out.
module serial4_tx #(
   parameter int unsigned WIDTH        = 4,
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data,
   input  logic             load,
   output logic             ready,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   localparam int unsigned DIV_W =
      (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned IDX_W =
      (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] shift_d;
   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] idx_d;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;
   logic             tick;
   logic             sout_q;
   logic             ready_q;
   logic             busy_q;
   logic             done_q;

   // tick marks the last clock of the current bit period
   always_comb begin
      tick    = (div_q == DIV_LAST);
      div_d   = tick ? '0 : div_q + DIV_W'(1);
      shift_d = shift_q >> 1;
      idx_d   = idx_q + IDX_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         div_q   <= '0;
         sout_q  <= 1'b1;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (load) begin
                  shift_q <= data;
                  div_q   <= '0;
                  idx_q   <= '0;
                  state_q <= S_START;
                  sout_q  <= 1'b0;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            S_START: begin
               div_q <= div_d;
               if (tick) begin
                  state_q <= S_DATA;
                  idx_q   <= '0;
                  sout_q  <= shift_q[0];
               end
            end
            S_DATA: begin
               div_q <= div_d;
               if (tick) begin
                  if (idx_q == IDX_LAST) begin
                     state_q <= S_STOP;
                     sout_q  <= 1'b1;
                  end else begin
                     // present the next bit on the same edge that shifts
                     shift_q <= shift_d;
                     idx_q   <= idx_d;
                     sout_q  <= shift_d[0];
                  end
               end
            end
            S_STOP: begin
               div_q <= div_d;
               if (tick) begin
                  state_q <= S_IDLE;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               sout_q  <= 1'b1;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign sout  = sout_q;
   assign ready = ready_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule
